// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART controller: 16-byte register window, one-byte TX holding
// register with a start/busy handshake FSM, and a small RX FIFO.
module mmio_uart_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'd64,
  parameter int          RX_DEPTH     = 4,
  parameter int          BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] WD,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        io_sel,
  output logic [31:0] RD,
  output logic        rd_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} txState_e;

  txState_e       state_q;
  logic [7:0]     hold_q;
  logic           holdFull_q;
  logic           txDrop_q;
  logic [TW-1:0]  timeout_q;
  logic           txStart_q;
  logic [7:0]     txData_q;

  logic [7:0]     fifo_q [RX_DEPTH];
  logic [PW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;

  logic [31:0]    rdData_q, rdData_d;
  logic           rdValid_q;

  logic [1:0]     regSel;
  logic           wrEn, rdEn, txWr, ctrlWr, clrSticky, flush;
  logic           fifoEmpty, fifoFull, rxPop, rxPush;
  logic [3:0]     countField;
  logic           unusedBits;

  assign io_sel    = (address[31:4] == BASE_ADDR[31:4]);
  assign regSel    = address[3:2];
  assign wrEn      = mem_write & io_sel;
  // A simultaneous store wins; the load is dropped entirely.
  assign rdEn      = mem_read & io_sel & ~mem_write;
  assign txWr      = wrEn && (regSel == 2'd0);
  assign ctrlWr    = wrEn && (regSel == 2'd3);
  assign clrSticky = ctrlWr & WD[0];
  assign flush     = ctrlWr & WD[1];
  assign unusedBits = ^{address[1:0], WD[31:8]};

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(RX_DEPTH));
  assign rxPop     = rdEn && (regSel == 2'd1) && !fifoEmpty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rxPush    = rx_valid && (!fifoFull || rxPop) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      txDrop_q   <= 1'b0;
      timeout_q  <= '0;
      txStart_q  <= 1'b0;
      txData_q   <= '0;
    end else begin
      txStart_q <= 1'b0;
      if (clrSticky) txDrop_q <= 1'b0;
      if (txWr) begin
        if (!holdFull_q) begin
          hold_q     <= WD[7:0];
          holdFull_q <= 1'b1;
        end else begin
          txDrop_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (holdFull_q && !tx_busy) begin
            txData_q  <= hold_q;
            txStart_q <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          holdFull_q <= 1'b0;
          timeout_q  <= '0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state_q <= WAIT_DONE;
          else if (timeout_q == TW'(BUSY_TIMEOUT - 1)) state_q <= IDLE;
          else timeout_q <= timeout_q + TW'(1);
        end
        WAIT_DONE: begin
          if (!tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start = txStart_q;
  assign tx_data  = txData_q;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (rxPush) wrPtr_d = wrPtr_q + PW'(1);
    if (rxPop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({rxPush, rxPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clrSticky) overflow_d = 1'b0;
    if (rx_valid && fifoFull && !rxPop && !flush) overflow_d = 1'b1;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rxPush) fifo_q[wrPtr_q] <= rx_data;
  end

  // A 16-deep FIFO can hold 16 entries but the field is 4 bits, so saturate.
  always_comb begin
    countField = 4'(count_q);
    if (int'(count_q) > 15) countField = 4'hF;
  end

  always_comb begin
    rdData_d = '0;
    case (regSel)
      2'd1:    rdData_d = fifoEmpty ? 32'd0 : {24'd0, fifo_q[rdPtr_q]};
      2'd2:    rdData_d = {24'd0, countField, txDrop_q, overflow_q, !fifoEmpty, !holdFull_q};
      default: rdData_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= rdEn;
      if (rdEn) rdData_q <= rdData_d;
    end
  end

  assign RD       = rdData_q;
  assign rd_valid = rdValid_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl with a simple UART transmitter model
// that raises tx_busy for a programmable number of cycles after each start.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] WD;
  logic        mem_write;
  logic        mem_read;
  logic        io_sel;
  logic [31:0] RD;
  logic        rd_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int   totalCount = 0;
  int   passCount  = 0;
  int   busyLen    = 0;
  int   busyLeft   = 0;
  int   startCount = 0;
  logic forceBusy  = 1'b0;

  mmio_uart_ctrl #(
    .BASE_ADDR   (32'd64),
    .RX_DEPTH    (4),
    .BUSY_TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .WD       (WD),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .io_sel   (io_sel),
    .RD       (RD),
    .rd_valid (rd_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  // Transmitter model: counts start pulses and holds busy for busyLen cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      startCount++;
      busyLeft = busyLen;
    end
    tx_busy = forceBusy || (busyLeft > 0);
    if (busyLeft > 0) busyLeft--;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic we, input logic re);
    address   = addr;
    WD        = data;
    mem_write = we;
    mem_read  = re;
    @(posedge clk); #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 1'b1, 1'b0);
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
    applyStimulus(addr, 32'd0, 1'b0, 1'b1);
    checkOutput(tag, RD, expected);
    checkOutput({tag, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic pushRx(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int found;
    int n;
    reset = 1'b1; address = '0; WD = '0; mem_write = 1'b0; mem_read = 1'b0;
    rx_data = '0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_RD", RD, 32'd0);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_tx_start", tx_start, 1'b0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    checkRead("status_after_reset", 32'd72, 32'h1);
    idle(1);
    checkOutput("rd_valid_one_cycle", rd_valid, 1'b0);
    checkOutput("rd_holds", RD, 32'h1);

    address = 32'd79; #1; checkOutput("io_sel_79", io_sel, 1'b1);
    address = 32'd80; #1; checkOutput("io_sel_80", io_sel, 1'b0);
    address = 32'd63; #1; checkOutput("io_sel_63", io_sel, 1'b0);
    address = 32'd64; #1; checkOutput("io_sel_64", io_sel, 1'b1);

    // Single byte, transmitter busy for 10 cycles.
    busyLen = 10;
    writeReg(32'd64, 32'h0000_0041);
    idle(1);
    checkOutput("tx1_start", tx_start, 1'b1);
    checkOutput("tx1_data", tx_data, 8'h41);
    idle(1);
    checkOutput("tx1_start_one_cycle", tx_start, 1'b0);
    idle(20);
    checkOutput("tx1_start_count", startCount, 1);
    checkOutput("tx1_busy_done", tx_busy, 1'b0);
    checkRead("tx1_status_ready", 32'd72, 32'h1);

    // Queue a byte behind an in-flight one, third write is dropped.
    writeReg(32'd64, 32'h41);
    idle(1);
    checkOutput("tx2_first_start", tx_start, 1'b1);
    idle(1);
    writeReg(32'd64, 32'h42);
    writeReg(32'd64, 32'h43);
    checkRead("tx2_status_drop", 32'd72, 32'h8);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      idle(1);
      if (tx_start) found = 1;
    end
    checkOutput("tx2_second_start_seen", found, 1);
    checkOutput("tx2_second_data", tx_data, 8'h42);
    writeReg(32'd76, 32'h1);
    checkRead("tx2_status_cleared", 32'd72, 32'h1);
    idle(20);
    checkOutput("tx2_start_count", startCount, 3);

    // RX overflow and drain.
    for (int i = 0; i < 5; i++) pushRx(8'(8'h10 + i));
    checkRead("rx_status_full_ovf", 32'd72, 32'h47);
    for (int i = 0; i < 4; i++) checkRead("rx_pop", 32'd68, 32'h10 + i);
    checkRead("rx_pop_empty", 32'd68, 32'h0);
    checkRead("rx_status_empty_ovf", 32'd72, 32'h5);

    writeReg(32'd76, 32'h1);
    pushRx(8'h55);
    checkRead("rx_avail_latency", 32'd72, 32'h13);
    checkRead("rx_pop_55", 32'd68, 32'h55);

    // Push and pop together while full; write pointer wraps.
    for (int i = 0; i < 4; i++) pushRx(8'(8'h20 + i));
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    applyStimulus(32'd68, 32'd0, 1'b0, 1'b1);
    rx_valid = 1'b0;
    checkOutput("rx_pushpop_data", RD, 32'h20);
    checkRead("rx_pushpop_status", 32'd72, 32'h43);
    checkRead("rx_wrap_21", 32'd68, 32'h21);
    checkRead("rx_wrap_22", 32'd68, 32'h22);
    checkRead("rx_wrap_23", 32'd68, 32'h23);
    checkRead("rx_wrap_AA", 32'd68, 32'hAA);

    // Flush coinciding with a push leaves the FIFO empty.
    pushRx(8'h30);
    pushRx(8'h31);
    rx_data = 8'h99;
    rx_valid = 1'b1;
    writeReg(32'd76, 32'h2);
    rx_valid = 1'b0;
    checkRead("flush_status", 32'd72, 32'h1);
    checkRead("txdata_read_zero", 32'd64, 32'h0);
    checkRead("status_again", 32'd72, 32'h1);
    checkRead("ctrl_read_zero", 32'd76, 32'h0);
    applyStimulus(32'd72, 32'hFF, 1'b1, 1'b1);
    checkOutput("wr_rd_same_cycle_valid", rd_valid, 1'b0);
    checkRead("ro_write_no_effect", 32'd72, 32'h1);

    // Busy never rises: timeout, then reset during WAIT_DONE.
    busyLen = 0;
    writeReg(32'd64, 32'h61);
    idle(1);
    checkOutput("to_start", tx_start, 1'b1);
    checkOutput("to_data", tx_data, 8'h61);
    idle(1);
    writeReg(32'd64, 32'h62);
    n = 2;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      idle(1);
      n++;
      if (tx_start) found = 1;
    end
    checkOutput("to_second_seen", found, 1);
    checkOutput("to_gap_cycles", n, 17);
    checkOutput("to_second_data", tx_data, 8'h62);
    forceBusy = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("midreset_tx_start", tx_start, 1'b0);
    checkOutput("midreset_tx_data", tx_data, 8'h00);
    checkOutput("midreset_RD", RD, 32'h0);
    idle(5);
    checkOutput("midreset_no_start", startCount, 5);
    checkRead("midreset_status", 32'd72, 32'h1);
    forceBusy = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
